jump_sequencer: RTL
===================

# jump_sequencer

Phase controller for the jay's jump. It accepts a one-cycle jump request and steps through RISE, HOLD and FALL phases, each lasting a parameterised number of game ticks. An internal phase-step counter and a height up/down counter supply the jump profile to the sprite/collision datapath. The block sits between the input debouncer/tick generator and the renderer.

## Interface
- CW, 4: width of `step` and `height`. Each *_TICKS value must be in 1..2^CW-1.
- RISE_TICKS, 6: game ticks spent in RISE.
- HOLD_TICKS, 2: game ticks spent in HOLD.
- FALL_TICKS, 6: game ticks spent in FALL.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset. rst=0 resets the block at the next edge.
- tick  in  1  one-cycle game-tick strobe.
- start  in  1  jump request, level-sampled every cycle.
- abort  in  1  forces a return to IDLE (e.g. on a collision).
- phase  out  2  00 IDLE, 01 RISE, 10 HOLD, 11 FALL (registered).
- step  out  CW  ticks elapsed in the current phase (registered).
- height  out  CW  jump height above ground (registered).
- busy  out  1  phase != IDLE (decoded from registered phase).
- done  out  1  one-cycle pulse marking normal completion of FALL.

## Operation
Reset value of every output:
- phase=IDLE, step=0, height=0, done=0, busy=0.

IDLE:
- start=1 and abort=0 moves to RISE at the next edge, with step=0 and height=0.
- tick is ignored.

RISE:
- Each tick increments step and increments height.
- A tick with step==RISE_TICKS-1 moves to HOLD with step=0. height has then reached RISE_TICKS.

HOLD:
- Each tick increments step; height is held.
- A tick with step==HOLD_TICKS-1 moves to FALL with step=0.

FALL:
- Each tick increments step and decrements height. height saturates at 0 and never wraps.
- A tick with step==FALL_TICKS-1 moves to IDLE, forces height=0 and asserts done for exactly one cycle.

Priority and boundary rules:
- **start while busy:** ignored. Requests are not queued.
- **start held high:** a new jump starts on the first cycle back in IDLE, i.e. the cycle after done. start is level-sensitive, not edge-detected.
- **abort:** in any non-IDLE phase, abort=1 moves to IDLE at the next edge with step=0 and height=0. done is not asserted. abort beats tick and start in the same cycle. In IDLE, abort=1 blocks start.
- **Reset mid-jump:** rst=0 overrides everything, including a tick on the same edge, and produces the reset values.
- **Ticks outside a phase's terminal count:** step stays within 0..*_TICKS-1; no wrap is ever observable.
- **Phase length:** a phase lasts exactly its *_TICKS ticks, independent of the cycle spacing between ticks.

## Timing
- **start latency:** start=1 at edge N gives phase=RISE and busy=1 after edge N. The first tick is counted on edge N+1 or later.
- **Per-tick update:** one tick produces one step/height update, registered and visible in the cycle after the tick.
- **done:** high during the first IDLE cycle after a normal FALL completion, and low the following cycle unless another FALL completes.
- **Duration:** a full jump with back-to-back ticks (tick=1 every cycle) takes RISE_TICKS+HOLD_TICKS+FALL_TICKS cycles from entering RISE to done.
- **Output paths:** all outputs are registered except busy. No combinational path exists from the inputs to the outputs.

## Test plan
- **Reset:** hold rst=0 for 5 cycles with start=1 and tick=1 -> phase=0, step=0, height=0, busy=0, done=0 throughout. Release rst -> RISE begins the cycle after release.
- **Nominal jump:** defaults, tick every 4 cycles, single start pulse.
  - height sequence 1..6, then held at 6 for 2 ticks, then 5..0.
  - phase goes 01 -> 10 -> 11 -> 00.
  - done is a single pulse exactly 14 ticks after start.
  - busy is high for the whole jump.
- **Back-to-back ticks with start held high:** tick=1 every cycle, start=1 continuously -> done every 15 cycles (14 phase cycles plus 1 IDLE cycle). No overlap, and height never exceeds 6.
- **start while busy:** pulse start in RISE, HOLD and FALL -> no phase or step change. Jump timing is identical to the nominal jump.
- **Abort mid-FALL:** abort at FALL step=3 together with a tick -> next cycle IDLE, height=0, step=0, done never asserted. A start one cycle later launches a fresh RISE.
- **Corner parameters:** CW=3, RISE=HOLD=FALL=1, tick every cycle -> phase sequence RISE, HOLD, FALL, IDLE. height goes 1, 1, 0. done is asserted 3 cycles after entering RISE.

Source files
------------

// File: rtl/jump_sequencer.sv
// jump_sequencer: phase controller for the jay's jump.
// A start request walks the block through RISE, HOLD and FALL. Each phase
// lasts a fixed number of game ticks. The block also drives a step counter
// and a height profile for the sprite/collision datapath.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-low reset
//   tick   - one-cycle game-tick strobe
//   start  - jump request, level-sampled
//   abort  - forces a return to IDLE
//   phase  - 00 IDLE, 01 RISE, 10 HOLD, 11 FALL (registered)
//   step   - ticks elapsed in the current phase (registered)
//   height - jump height above ground (registered)
//   busy   - phase != IDLE (decoded from registered phase)
//   done   - one-cycle pulse on normal completion of FALL (registered)
module jump_sequencer #(
    parameter int unsigned CW         = 4,
    parameter int unsigned RISE_TICKS = 6,
    parameter int unsigned HOLD_TICKS = 2,
    parameter int unsigned FALL_TICKS = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic          abort,
    output logic [1:0]    phase,
    output logic [CW-1:0] step,
    output logic [CW-1:0] height,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RISE = 2'b01,
        HOLD = 2'b10,
        FALL = 2'b11
    } phase_t;

    localparam logic [CW-1:0] RISE_LAST = CW'(RISE_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] FALL_LAST = CW'(FALL_TICKS - 1);

    phase_t state;

    // Phase FSM with registered step/height/done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            step   <= '0;
            height <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                // Abort beats tick and start; no completion pulse.
                state  <= IDLE;
                step   <= '0;
                height <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state  <= RISE;
                            step   <= '0;
                            height <= '0;
                        end
                    end
                    RISE: begin
                        if (tick) begin
                            height <= height + CW'(1);
                            if (step == RISE_LAST) begin
                                state <= HOLD;
                                step  <= '0;
                            end else begin
                                step <= step + CW'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            if (step == HOLD_LAST) begin
                                state <= FALL;
                                step  <= '0;
                            end else begin
                                step <= step + CW'(1);
                            end
                        end
                    end
                    FALL: begin
                        if (tick) begin
                            if (step == FALL_LAST) begin
                                // Landing: height forced to ground regardless of profile.
                                state  <= IDLE;
                                step   <= '0;
                                height <= '0;
                                done   <= 1'b1;
                            end else begin
                                step   <= step + CW'(1);
                                // Saturate at ground when FALL outlasts RISE.
                                height <= (height != '0) ? height - CW'(1) : '0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign phase = state;
    assign busy  = (state != IDLE);

endmodule
